// File: rtl/pixel_point_op_pipe.sv
// Streaming per-pixel point operation (brighten, darken, threshold, invert) with a
// per-frame config lock, a two-stage valid/ready pipeline and per-frame beat counting.
`timescale 1ns/1ps

module pixel_point_op_pipe #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned CNT_W    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                select,
  input  logic [PIX_W-1:0]          value,
  input  logic [PIX_W-1:0]          threshold,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_W*CHANNELS-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PIX_W*CHANNELS-1:0] out_data,
  output logic                      out_last,
  output logic [CNT_W-1:0]          pix_count,
  output logic                      frame_done
);

  localparam int unsigned     DataW  = PIX_W * CHANNELS;
  localparam logic [PIX_W-1:0] MaxPix = {PIX_W{1'b1}};
  localparam logic [CNT_W-1:0] MaxCnt = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StInFrame} state_e;

  state_e           state_q;
  logic [1:0]       cfg_select_q;
  logic [PIX_W-1:0] cfg_value_q;
  logic [PIX_W-1:0] cfg_thresh_q;

  logic             s1_valid_q;
  logic [DataW-1:0] s1_data_q;
  logic             s1_last_q;
  logic [1:0]       s1_select_q;
  logic [PIX_W-1:0] s1_value_q;
  logic [PIX_W-1:0] s1_thresh_q;

  logic             out_valid_q;
  logic [DataW-1:0] out_data_q;
  logic             out_last_q;
  logic [CNT_W-1:0] pix_count_q;
  logic             frame_done_q;

  logic             en;
  logic             accept;
  logic             out_hs;
  logic [1:0]       eff_select;
  logic [PIX_W-1:0] eff_value;
  logic [PIX_W-1:0] eff_thresh;
  logic [DataW-1:0] result;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign en       = !out_valid_q | out_ready;
  assign in_ready = en & !rst;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  // The first beat of a frame uses the live config; later beats use the latched copy.
  always_comb begin
    eff_select = select;
    eff_value  = value;
    eff_thresh = threshold;
    if (state_q == StInFrame) begin
      eff_select = cfg_select_q;
      eff_value  = cfg_value_q;
      eff_thresh = cfg_thresh_q;
    end
  end

  // Config FSM: latch config on the first accepted beat, release on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cfg_select_q <= '0;
      cfg_value_q  <= '0;
      cfg_thresh_q <= '0;
    end else if (accept) begin
      case (state_q)
        StIdle: begin
          cfg_select_q <= select;
          cfg_value_q  <= value;
          cfg_thresh_q <= threshold;
          state_q      <= in_last ? StIdle : StInFrame;
        end
        default: begin
          if (in_last) state_q <= StIdle;
        end
      endcase
    end
  end

  // Stage 1: capture the beat together with the config it must be processed with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_select_q <= '0;
      s1_value_q  <= '0;
      s1_thresh_q <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q   <= in_data;
        s1_last_q   <= in_last;
        s1_select_q <= eff_select;
        s1_value_q  <= eff_value;
        s1_thresh_q <= eff_thresh;
      end
    end
  end

  // Per-channel point operation on the stage-1 sample.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [PIX_W-1:0] p;
    logic [PIX_W:0]   sum;
    logic [PIX_W-1:0] r;

    assign p   = s1_data_q[k*PIX_W +: PIX_W];
    assign sum = {1'b0, p} + {1'b0, s1_value_q};

    // Select the operation result for this channel.
    always_comb begin
      r = '0;
      unique case (s1_select_q)
        2'b00: r = sum[PIX_W] ? MaxPix : sum[PIX_W-1:0];
        2'b01: r = (p >= s1_value_q) ? (p - s1_value_q) : '0;
        2'b10: r = (p > s1_thresh_q) ? MaxPix : '0;
        2'b11: r = MaxPix - p;
      endcase
    end

    assign result[k*PIX_W +: PIX_W] = r;
  end

  // Stage 2: registered result drives the output stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q & s1_last_q;
      if (s1_valid_q) out_data_q <= result;
    end
  end

  // Beat counter (saturating) and end-of-frame pulse, both keyed on output handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (out_hs) begin
        if (out_last_q) begin
          pix_count_q  <= '0;
          frame_done_q <= 1'b1;
        end else if (pix_count_q != MaxCnt) begin
          pix_count_q <= pix_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign pix_count  = pix_count_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_point_op_pipe.sv
// Directed bench for pixel_point_op_pipe (3 channels): operations, config lock,
// back-pressure, frame boundaries and reset behaviour.
`timescale 1ns/1ps

module tb_pixel_point_op_pipe;

  localparam int unsigned PW = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned CW = 20;
  localparam int unsigned DW = PW * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    select = 2'b00;
  logic [PW-1:0] value = '0;
  logic [PW-1:0] threshold = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] pix_count;
  logic          frame_done;

  int checks = 0;
  int passed = 0;

  pixel_point_op_pipe #(
    .PIX_W   (PW),
    .CHANNELS(CH),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .select    (select),
    .value     (value),
    .threshold (threshold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .pix_count (pix_count),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  logic [CW-1:0] got_cnt[$];
  int unsigned   got_cyc[$];
  int unsigned   acc_cyc[$];
  int            fd_cnt = 0;
  int unsigned   fd_cyc = 0;
  int unsigned   last_hs_cyc = 0;
  int            stall_viol = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cnt.push_back(pix_count);
        got_cyc.push_back(cyc);
        if (out_last) last_hs_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (held_v && (!out_valid || out_data !== held_d || out_last !== held_l)) stall_viol++;
      if (out_valid && !out_ready && in_ready) stall_viol++;
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
    end else begin
      held_v = 1'b0;
    end
  end

  function automatic logic [DW-1:0] rep(input logic [PW-1:0] p);
    return {p, p, p};
  endfunction

  function automatic logic [PW-1:0] ref_op(input logic [1:0] s, input logic [PW-1:0] v,
                                           input logic [PW-1:0] t, input logic [PW-1:0] p);
    int pi, vi, ti;
    pi = int'(p);
    vi = int'(v);
    ti = int'(t);
    case (s)
      2'b00:   return (pi + vi > 255) ? 8'hFF : 8'(pi + vi);
      2'b01:   return (pi >= vi) ? 8'(pi - vi) : 8'h00;
      2'b10:   return (pi > ti) ? 8'hFF : 8'h00;
      default: return 8'(255 - pi);
    endcase
  endfunction

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_cnt.delete();
    got_cyc.delete();
    acc_cyc.delete();
    fd_cnt = 0;
    stall_viol = 0;
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int b;
    b = 0;
    while (got_data.size() < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (got_data.size() < n) begin
      checks++;
      $display("FAIL wait_out_timeout: got %0d beats, required %0d", got_data.size(), n);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else passed++;
    checks++; if (pix_count !== '0) $display("FAIL rst_pix_count: got %0d want 0", pix_count); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_brighten();
    logic [PW-1:0] e[3] = '{8'h50, 8'hFF, 8'hFF};
    clear_mon();
    select = 2'b00; value = 8'h40; out_ready = 1'b1;
    send(rep(8'h10), 1'b0);
    send(rep(8'hC0), 1'b0);
    send(rep(8'hFF), 1'b1);
    wait_out(3);
    checks++; if (got_data.size() != 3) $display("FAIL br_count: got %0d want 3", got_data.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_data[i] !== rep(e[i])) $display("FAIL br_data%0d: got %h want %h", i, got_data[i], rep(e[i])); else passed++;
      checks++; if (got_last[i] !== (i == 2)) $display("FAIL br_last%0d: got %b want %b", i, got_last[i], i == 2); else passed++;
      checks++; if (got_cnt[i] !== CW'(i)) $display("FAIL br_pixcnt%0d: got %0d want %0d", i, got_cnt[i], i); else passed++;
      checks++; if (got_cyc[i] - acc_cyc[i] != 2) $display("FAIL br_latency%0d: got %0d want 2", i, got_cyc[i] - acc_cyc[i]); else passed++;
    end
    checks++; if (pix_count !== '0) $display("FAIL br_pixcnt_end: got %0d want 0", pix_count); else passed++;
    checks++; if (fd_cnt != 1) $display("FAIL br_frame_done_cnt: got %0d want 1", fd_cnt); else passed++;
    checks++; if (fd_cyc != last_hs_cyc + 1) $display("FAIL br_frame_done_time: got %0d want %0d", fd_cyc, last_hs_cyc + 1); else passed++;
  endtask

  task automatic test_ops();
    logic [PW-1:0] e[5] = '{8'h00, 8'h80, 8'h00, 8'hFF, 8'hC3};
    logic          el[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [CW-1:0] ec[5] = '{20'd0, 20'd1, 20'd0, 20'd1, 20'd0};
    clear_mon();
    select = 2'b01; value = 8'h40;
    send(rep(8'h10), 1'b0);
    send(rep(8'hC0), 1'b1);
    select = 2'b10; threshold = 8'h82;
    send(rep(8'h82), 1'b0);
    send(rep(8'h83), 1'b1);
    select = 2'b11;
    send(rep(8'h3C), 1'b1);
    wait_out(5);
    for (int i = 0; i < 5; i++) begin
      checks++; if (got_data[i] !== rep(e[i])) $display("FAIL ops_data%0d: got %h want %h", i, got_data[i], rep(e[i])); else passed++;
      checks++; if (got_last[i] !== el[i]) $display("FAIL ops_last%0d: got %b want %b", i, got_last[i], el[i]); else passed++;
      checks++; if (got_cnt[i] !== ec[i]) $display("FAIL ops_pixcnt%0d: got %0d want %0d", i, got_cnt[i], ec[i]); else passed++;
    end
    checks++; if (fd_cnt != 3) $display("FAIL ops_frame_done_cnt: got %0d want 3", fd_cnt); else passed++;
  endtask

  task automatic test_config_lock();
    logic [PW-1:0] e[4] = '{8'h30, 8'h40, 8'h50, 8'hC3};
    clear_mon();
    select = 2'b00; value = 8'h10;
    send(rep(8'h20), 1'b0);
    select = 2'b11; value = 8'h99;
    send(rep(8'h30), 1'b0);
    send(rep(8'h40), 1'b1);
    send(rep(8'h3C), 1'b1);
    wait_out(4);
    checks++; if (got_data.size() != 4) $display("FAIL lock_count: got %0d want 4", got_data.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== rep(e[i])) $display("FAIL lock_data%0d: got %h want %h", i, got_data[i], rep(e[i])); else passed++;
    end
  endtask

  task automatic test_channels();
    clear_mon();
    select = 2'b00; value = 8'h20;
    send(24'hF01080, 1'b1);
    wait_out(1);
    checks++; if (got_data[0] !== 24'hFF30A0) $display("FAIL chan_data: got %h want ff30a0", got_data[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] e[4] = '{8'h11, 8'h12, 8'hF0, 8'h0F};
    logic [CW-1:0] ec[4] = '{20'd0, 20'd1, 20'd0, 20'd1};
    clear_mon();
    select = 2'b00; value = 8'h10;
    send(rep(8'h01), 1'b0);
    send(rep(8'h02), 1'b1);
    select = 2'b11;
    @(posedge clk);
    #1;
    send(rep(8'h0F), 1'b0);
    send(rep(8'hF0), 1'b1);
    wait_out(4);
    checks++; if (acc_cyc[2] != got_cyc[1]) $display("FAIL b2b_overlap: accept cyc %0d want %0d", acc_cyc[2], got_cyc[1]); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== rep(e[i])) $display("FAIL b2b_data%0d: got %h want %h", i, got_data[i], rep(e[i])); else passed++;
      checks++; if (got_cnt[i] !== ec[i]) $display("FAIL b2b_pixcnt%0d: got %0d want %0d", i, got_cnt[i], ec[i]); else passed++;
    end
    checks++; if (fd_cnt != 2) $display("FAIL b2b_frame_done_cnt: got %0d want 2", fd_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    localparam int N = 1000;
    logic [DW-1:0] d[N];
    logic [DW-1:0] exp_d[N];
    int errs, nlast, first_bad;
    clear_mon();
    select = 2'b00; value = 8'h90;
    for (int i = 0; i < N; i++) begin
      d[i] = 24'($urandom);
      for (int k = 0; k < CH; k++) exp_d[i][k*PW +: PW] = ref_op(2'b00, 8'h90, 8'h00, d[i][k*PW +: PW]);
    end
    fork
      begin
        for (int i = 0; i < N; i++) send(d[i], i == N - 1);
      end
      begin
        int n;
        n = 0;
        while (got_data.size() < N && n < 20000) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1, 0));
          n++;
        end
        out_ready = 1'b1;
      end
    join
    wait_out(N);
    errs = 0; nlast = 0; first_bad = -1;
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      if (got_data[i] !== exp_d[i] || got_cnt[i] !== CW'(i) || got_last[i] !== (i == N - 1)) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      if (got_last[i]) nlast++;
    end
    checks++; if (got_data.size() != N) $display("FAIL bp_count: got %0d want %0d", got_data.size(), N); else passed++;
    checks++; if (errs != 0) $display("FAIL bp_sequence: %0d bad beats (first %0d), want 0", errs, first_bad); else passed++;
    checks++; if (nlast != 1) $display("FAIL bp_last_cnt: got %0d want 1", nlast); else passed++;
    checks++; if (stall_viol != 0) $display("FAIL bp_stall: got %0d violations want 0", stall_viol); else passed++;
    checks++; if (fd_cnt != 1) $display("FAIL bp_frame_done_cnt: got %0d want 1", fd_cnt); else passed++;
    checks++; if (pix_count !== '0) $display("FAIL bp_pixcnt_end: got %0d want 0", pix_count); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    out_ready = 1'b1;
    select = 2'b11; value = 8'h00;
    send(rep(8'h01), 1'b0);
    send(rep(8'h02), 1'b0);
    send(rep(8'h03), 1'b0);
    checks++; if (pix_count !== CW'(1)) $display("FAIL rm_pre_pixcnt: got %0d want 1", pix_count); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL rm_pre_valid: got %b want 1", out_valid); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (pix_count !== '0) $display("FAIL rm_pixcnt: got %0d want 0", pix_count); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL rm_in_ready: got %b want 0", in_ready); else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    select = 2'b00; value = 8'h10;
    send(rep(8'h20), 1'b1);
    wait_out(1);
    checks++; if (got_data.size() != 1) $display("FAIL rm_count: got %0d want 1", got_data.size()); else passed++;
    checks++; if (got_data[0] !== rep(8'h30)) $display("FAIL rm_data: got %h want %h", got_data[0], rep(8'h30)); else passed++;
    checks++; if (got_cnt[0] !== '0) $display("FAIL rm_pixcnt_restart: got %0d want 0", got_cnt[0]); else passed++;
    checks++; if (fd_cnt != 1) $display("FAIL rm_frame_done_cnt: got %0d want 1", fd_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_brighten();
    test_ops();
    test_config_lock();
    test_channels();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pixel_point_op_pipe.md
# pixel_point_op_pipe

Parametrised, streaming pixel point-operation engine for the image-processing chain. It applies one of four per-pixel operations to a valid/ready pixel stream: saturating brighten, saturating darken, binary threshold and invert. The operation is selected by `select`, with `value` and `threshold` operands. It handles N channels per beat, locks its configuration per frame, tolerates output back-pressure, and reports per-frame pixel counts. It sits between the pixel source (memory reader) and the pixel sink (writer or next filter).

## Interface
- PIX_W, 8, bits per channel sample
- CHANNELS, 1, samples per beat (e.g. 3 for RGB), processed independently and identically
- CNT_W, 20, width of the output-beat counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- select  in  2  00 brighten, 01 darken, 10 threshold, 11 invert
- value  in  PIX_W  brighten/darken operand
- threshold  in  PIX_W  threshold level
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  PIX_W*CHANNELS  channel k at bits [k*PIX_W +: PIX_W]
- in_last  in  1  final beat of the frame
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts the beat
- out_data  out  PIX_W*CHANNELS  result, same packing as in_data
- out_last  out  1  in_last delayed with its beat
- pix_count  out  CNT_W  output beats accepted so far in the current frame
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted

## Operation
- MAX = 2^PIX_W − 1. The per-channel function of sample p is:
  - 00: min(p + value, MAX), computed in PIX_W+1 bits.
  - 01: p ≥ value ? p − value : 0.
  - 10: p > threshold ? MAX : 0. p == threshold gives 0.
  - 11: MAX − p.
- Config FSM states are IDLE and IN_FRAME.
  - IDLE: on an accepted beat (in_valid & in_ready), `select`/`value`/`threshold` are latched into cfg registers. That same beat uses the live inputs. Go to IN_FRAME unless in_last is set.
  - IN_FRAME: every beat uses the latched cfg. Changes on the config inputs are ignored. An accepted beat with in_last returns the FSM to IDLE.
  - A single-beat frame (in_last on the first beat) stays in IDLE.
- Pipeline has two register stages:
  - S1 holds data, last and the effective cfg.
  - S2 holds the computed result and drives out_*.
- Advance enable en = !out_valid | out_ready. Both stages load only when en is high, and in_ready = en & !rst.
- Counter and frame pulse:
  - pix_count increments on each out_valid & out_ready and saturates at 2^CNT_W − 1.
  - On the out_last handshake, pix_count clears to 0 and frame_done pulses high the following cycle.

## Timing
- Latency is 2 cycles from input accept to out_valid, with out_ready held high. Throughput is 1 beat/clk.
- When out_ready is low and out_valid is high:
  - S2 holds and out_data/out_last stay stable.
  - S1 holds and in_ready is low.
  - No beat is lost or duplicated.
- in_ready is combinational from out_valid/out_ready. There is no combinational path from in_* to out_*.
- Reset values: out_valid 0, out_data 0, out_last 0, pix_count 0, frame_done 0, in_ready 0, FSM IDLE, cfg 0, stage valids 0.
- Reset mid-frame discards all in-flight beats. The first accepted beat after reset starts a new frame.
- A simultaneous input accept and output handshake is legal every cycle.
- The out_last handshake and the next frame's first input accept may fall in the same cycle. The next frame's cfg is latched normally.

## Test plan
- Brighten, PIX_W=8, CHANNELS=1, select=00, value=0x40, pixels 0x10,0xC0,0xFF with in_last on the third -> outputs 0x50,0xFF,0xFF, each 2 cycles after accept. out_last on the third. pix_count 1,2 then 0. frame_done pulses once.
- Darken/threshold/invert:
  - select=01, value=0x40: 0x10,0xC0 -> 0x00,0x80.
  - select=10, threshold=0x82: 0x82,0x83 -> 0x00,0xFF.
  - select=11: 0x3C -> 0xC3.
- Config lock: start a select=00 frame, switch select to 11 after beat 1 -> every beat of the frame is still brightened. The next frame is inverted.
- Back-pressure: random out_ready (~50%) over a 1000-beat frame -> output sequence equals the reference model with no drops or duplicates. out_data is stable while stalled. in_ready is low whenever out_valid & !out_ready.
- CHANNELS=3, select=00, value=0x20, beat {0xF0,0x10,0x80} -> {0xFF,0x30,0xA0}. Channels are independent.
- Reset mid-frame: assert rst with 2 beats in flight -> out_valid drops immediately and pix_count is 0. After release, the first beat is treated as a new frame: cfg is latched from the live inputs and pix_count restarts at 0.
